// File: rtl/softmax_pkg.sv
// Shared types and constants for the stable fixed-point softmax.
package softmax_pkg;

  typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, DONE} state_t;

  // d*log2(e) is approximated as d + d/2 - d/16
  localparam int LOG2E_SH1 = 1;
  localparam int LOG2E_SH2 = 4;

  // Each exp term is at most 1.0, so the sum needs room for data_num of them
  function automatic int sum_width(input int data_width, input int data_num);
    return data_width + $clog2(data_num + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing QUO_W quotient bits, one per cycle.
// The quotient must fit in QUO_W bits (num >> QUO_W < den).
module seq_divider #(
  parameter int NUM_W = 41,
  parameter int DEN_W = 36,
  parameter int QUO_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quo
);

  localparam int CNT_W = $clog2(QUO_W + 1);

  // Handshake: start is a one-cycle request honoured only while busy is low;
  // done is high for exactly one cycle, and quo is valid in that same cycle.
  logic [DEN_W-1:0] rem_r, den_r, rem_nxt;
  logic [QUO_W-1:0] dq_r, dq_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [DEN_W:0]   trial;
  logic             ge;

  assign trial   = {rem_r, dq_r[QUO_W-1]};
  assign ge      = trial >= {1'b0, den_r};
  assign rem_nxt = ge ? DEN_W'(trial - {1'b0, den_r}) : trial[DEN_W-1:0];
  assign dq_nxt  = {dq_r[QUO_W-2:0], ge};
  assign done    = busy && (cnt_r == CNT_W'(1));
  assign quo     = dq_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      rem_r <= '0;
      den_r <= '0;
      dq_r  <= '0;
      cnt_r <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      rem_r <= DEN_W'(num >> QUO_W);
      den_r <= den;
      dq_r  <= num[QUO_W-1:0];
      cnt_r <= CNT_W'(QUO_W);
    end else if (busy) begin
      rem_r <= rem_nxt;
      dq_r  <= dq_nxt;
      cnt_r <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_stable.sv
// Numerically stable fixed-point softmax: max pass, exp pass, per-class divide.
// Optional feature: define SOFTMAX_ARGMAX_EN to add the out_argmax port.
module softmax_stable
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION_BITS = 20,
  parameter int DATA_NUM      = 10,
  parameter int ADR_WIDTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axisif_in_start,
  output logic                  axisif_out_done,
  output logic                  out_busy,
  output logic [ADR_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0] in_dataIn,
  output logic [ADR_WIDTH-1:0]  out_adrOut,
  output logic [DATA_WIDTH-1:0] out_dataOut,
  output logic                  out_wr,
`ifdef SOFTMAX_ARGMAX_EN
  output logic [ADR_WIDTH-1:0]  out_argmax,
`endif
  output state_t                dbg_state
);

  localparam int FB    = FRACTION_BITS;
  localparam int SUM_W = sum_width(DATA_WIDTH, DATA_NUM);
  localparam logic [ADR_WIDTH-1:0] LAST = ADR_WIDTH'(DATA_NUM - 1);

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] x, max_r, d_sat;
  logic signed [DATA_WIDTH:0]   diff;
  logic [SUM_W-1:0]             sum_r;
  logic [ADR_WIDTH-1:0]         cls;
  logic [FB:0]                  e_cur;
  logic [FB:0]                  e_buf [DATA_NUM];
  logic                         div_start, div_busy, div_done;
  logic [FB:0]                  div_quo;
`ifdef SOFTMAX_ARGMAX_EN
  logic [ADR_WIDTH-1:0]         idx_r;
`endif

  // 2^-y as a linear segment: ((2 - frac) >> (int + 1)), flushed to 0 once it underflows
  function automatic logic [FB:0] exp_approx(input logic signed [DATA_WIDTH-1:0] d);
    logic signed [DATA_WIDTH+1:0] dx, y;
    logic [DATA_WIDTH+1-FB:0]     n;
    logic [FB-1:0]                f;
    logic [FB+1:0]                m;
    dx = {{2{d[DATA_WIDTH-1]}}, d};
    y  = -(dx + (dx >>> LOG2E_SH1) - (dx >>> LOG2E_SH2));
    n  = y[DATA_WIDTH+1:FB];
    f  = y[FB-1:0];
    m  = {2'b10, {FB{1'b0}}} - {2'b00, f};
    if (n >= (DATA_WIDTH+2-FB)'(FB)) begin
      exp_approx = '0;
    end else begin
      m = m >> (n + 1'b1);
      exp_approx = m[FB:0];
    end
  endfunction

  assign x         = in_dataIn;
  assign diff      = {x[DATA_WIDTH-1], x} - {max_r[DATA_WIDTH-1], max_r};
  assign d_sat     = (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) ?
                     {1'b1, {(DATA_WIDTH-1){1'b0}}} : diff[DATA_WIDTH-1:0];
  assign e_cur     = exp_approx(d_sat);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (state == EXP) e_buf[out_adrIn] <= e_cur;
  end

  seq_divider #(
    .NUM_W (2*FB + 1),
    .DEN_W (SUM_W),
    .QUO_W (FB + 1)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start && !div_busy),
    .num   ({e_buf[cls], {FB{1'b0}}}),
    .den   (sum_r),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Start/done handshake: a start pulse is taken only from IDLE; busy then stays
  // high until the cycle in which done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      axisif_out_done <= 1'b0;
      out_busy        <= 1'b0;
      out_adrIn       <= '0;
      out_adrOut      <= '0;
      out_dataOut     <= '0;
      out_wr          <= 1'b0;
      max_r           <= '0;
      sum_r           <= '0;
      cls             <= '0;
      div_start       <= 1'b0;
`ifdef SOFTMAX_ARGMAX_EN
      idx_r           <= '0;
      out_argmax      <= '0;
`endif
    end else begin
      axisif_out_done <= 1'b0;
      out_wr          <= 1'b0;
      div_start       <= 1'b0;
      case (state)
        IDLE: begin
          if (axisif_in_start) begin
            state     <= MAX;
            out_busy  <= 1'b1;
            sum_r     <= '0;
            out_adrIn <= '0;
          end
        end
        MAX: begin
          if (out_adrIn == '0 || x > max_r) begin
            max_r <= x;
`ifdef SOFTMAX_ARGMAX_EN
            idx_r <= out_adrIn;
`endif
          end
          if (out_adrIn == LAST) begin
            out_adrIn <= '0;
            state     <= EXP;
          end else begin
            out_adrIn <= out_adrIn + 1'b1;
          end
        end
        EXP: begin
          sum_r <= sum_r + SUM_W'(e_cur);
          if (out_adrIn == LAST) begin
            out_adrIn <= '0;
            cls       <= '0;
            div_start <= 1'b1;
            state     <= DIV;
          end else begin
            out_adrIn <= out_adrIn + 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            out_dataOut <= DATA_WIDTH'(div_quo);
            out_adrOut  <= cls;
            out_wr      <= 1'b1;
            if (cls == LAST) begin
              state <= DONE;
            end else begin
              cls       <= cls + 1'b1;
              div_start <= 1'b1;
            end
          end
        end
        DONE: begin
          axisif_out_done <= 1'b1;
          out_busy        <= 1'b0;
`ifdef SOFTMAX_ARGMAX_EN
          out_argmax      <= idx_r;
`endif
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
